// File: rtl/cfu_issuer_pkg.sv
// cfu_issuer_pkg: shared types and constants for the CFU command issuer.
package cfu_issuer_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  typedef struct packed {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
  } cfu_cmd_t;
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } cfu_rsp_t;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/cfu_issuer_fifo.sv
// cfu_issuer_fifo: synchronous FIFO with a type parameter and active-low sync reset.
module cfu_issuer_fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  T mem_q [DEPTH];
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // a pop frees the slot in the same cycle, so push-on-full succeeds alongside it
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cfu_cmd_issuer.sv
// cfu_cmd_issuer: queues stream commands, issues them one at a time to a Cfu, queues results.
// Define CFU_ISSUER_PERF_EN to add the perf_issued / perf_wait_cycles counters.
module cfu_cmd_issuer
  import cfu_issuer_pkg::*;
#(
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_function_id,
  input  logic [31:0] in_inputs_0,
  input  logic [31:0] in_inputs_1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_error,
  output logic        busy,
  output logic [7:0]  dropped
`ifdef CFU_ISSUER_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_wait_cycles
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  cfu_cmd_t cmd_q, cmd_d, cmd_in, cmd_head;
  cfu_rsp_t rsp_in, rsp_head;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] dropped_q, dropped_d;
  logic cmd_full, cmd_empty, cmd_pop, rsp_full, rsp_empty, rsp_push;
  assign cmd_in = '{fid: in_function_id, in0: in_inputs_0, in1: in_inputs_1};
  assign in_ready = reset & !cmd_full;
  assign rsp_ready = reset;
  assign cmd_valid = state_q == ISSUE;
  assign cmd_payload_function_id = cmd_q.fid;
  assign cmd_payload_inputs_0 = cmd_q.in0;
  assign cmd_payload_inputs_1 = cmd_q.in1;
  assign out_valid = !rsp_empty;
  assign out_data = out_valid ? rsp_head.data : '0;
  assign out_error = out_valid & rsp_head.err;
  assign busy = (state_q != IDLE) | !cmd_empty;
  assign dropped = dropped_q;
  cfu_issuer_fifo #(.T(cfu_cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(in_valid & in_ready), .din(cmd_in),
    .pop(cmd_pop), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty)
  );
  cfu_issuer_fifo #(.T(cfu_rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .reset(reset), .push(rsp_push), .din(rsp_in),
    .pop(out_valid & out_ready), .dout(rsp_head), .full(rsp_full), .empty(rsp_empty)
  );
  // only one command is ever outstanding, so a non-full rsp FIFO in IDLE reserves its slot
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    timer_d = timer_q;
    cmd_pop = 1'b0;
    rsp_push = 1'b0;
    rsp_in = '{err: 1'b0, data: rsp_payload_outputs_0};
    dropped_d = (rsp_valid && state_q != WAIT_RSP && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    case (state_q)
      IDLE: if (!cmd_empty && !rsp_full) begin
        cmd_pop = 1'b1;
        cmd_d = cmd_head;
        state_d = ISSUE;
      end
      ISSUE: if (cmd_ready) begin
        state_d = WAIT_RSP;
        timer_d = '0;
      end
      WAIT_RSP: begin
        timer_d = timer_q + 1'b1;
        if (rsp_valid) begin
          rsp_push = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_push = 1'b1;
          rsp_in = '{err: 1'b1, data: TIMEOUT_DATA};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      timer_q <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      timer_q <= timer_d;
      dropped_q <= dropped_d;
    end
  end
`ifdef CFU_ISSUER_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d, perf_wait_q, perf_wait_d;
  always_comb begin
    perf_issued_d = (cmd_valid && cmd_ready) ? perf_issued_q + 32'd1 : perf_issued_q;
    perf_wait_d = (state_q != IDLE) ? perf_wait_q + 32'd1 : perf_wait_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_wait_q <= perf_wait_d;
    end
  end
  assign perf_issued = perf_issued_q;
  assign perf_wait_cycles = perf_wait_q;
`endif
endmodule
